// File: rtl/sensor_drain_dma_if.sv
// Bundles the sensor-controller read port and the memory write port of the drain engine.
// The master side is the drain engine; the slave side is the controller and memory.
interface sensor_drain_dma_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
);
    logic              sctrl_en;
    logic              sctrl_clear;
    logic [ADDR_W-1:0] sctrl_addr;
    logic [DATA_W-1:0] sctrl_out;
    logic              sctrl_interrupt;
    logic              wr_valid;
    logic              wr_ready;
    logic [31:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output sctrl_en, sctrl_clear, sctrl_addr,
        input  sctrl_out, sctrl_interrupt,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready
    );

    modport slave (
        input  sctrl_en, sctrl_clear, sctrl_addr,
        output sctrl_out, sctrl_interrupt,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/sensor_drain_dma.sv
// Drain engine: arms the sensor controller, waits for buffer-full, copies the frame to memory
// word by word over a valid/ready port, pulses clear, then holds a level interrupt until acked.
module sensor_drain_dma #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_en,
    input  logic [31:0]        cfg_dst_base,
    input  logic               irq_ack,
    sensor_drain_dma_if.master bus,
    output logic               busy,
    output logic               done_irq,
    output logic [31:0]        frame_sum,
    output logic [15:0]        frame_cnt
);
    typedef enum logic [2:0] {IDLE, ARM, READ, WRITE, CLEAR, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       base;
    logic [31:0]       sum;
    logic [31:0]       wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              last_word;
    logic              handshake;
    logic              start;

    assign last_word = (idx == ADDR_W'(DEPTH - 1));
    assign handshake = (state == WRITE) && bus.wr_ready;
    // Both paths into ARM restart the frame with a freshly latched base.
    assign start     = cfg_en && ((state == IDLE) || ((state == DONE) && irq_ack));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        busy            = 1'b1;
        done_irq        = 1'b0;
        bus.sctrl_en    = 1'b0;
        bus.sctrl_clear = 1'b0;
        bus.wr_valid    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cfg_en) state_nx = ARM;
            end
            ARM: begin
                bus.sctrl_en = 1'b1;
                if (!cfg_en)                   state_nx = IDLE;
                else if (bus.sctrl_interrupt) state_nx = READ;
            end
            READ: begin
                bus.sctrl_en = 1'b1;
                state_nx     = WRITE;
            end
            WRITE: begin
                bus.sctrl_en = 1'b1;
                bus.wr_valid = 1'b1;
                if (bus.wr_ready) state_nx = last_word ? CLEAR : READ;
            end
            CLEAR: begin
                bus.sctrl_clear = 1'b1;
                state_nx        = DONE;
            end
            DONE: begin
                done_irq = 1'b1;
                if (irq_ack) state_nx = cfg_en ? ARM : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            base      <= '0;
            sum       <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            frame_sum <= '0;
            frame_cnt <= '0;
        end else begin
            if (start) begin
                base <= cfg_dst_base & 32'hFFFF_FFFC;
                idx  <= '0;
                sum  <= '0;
            end
            if (state == READ) begin
                wr_data_q <= bus.sctrl_out;
                wr_addr_q <= base + (32'(idx) << 2);
                sum       <= sum + 32'(bus.sctrl_out);
            end
            if (handshake && !last_word) idx <= idx + ADDR_W'(1);
            if (state == CLEAR) begin
                frame_sum <= sum;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign bus.sctrl_addr = idx;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
endmodule

// File: tb/tb_sensor_drain_dma.sv
// Directed bench for sensor_drain_dma: a memory-array controller model plus a write logger
// feed per-scenario tasks that compare against hand-computed addresses, data and sums.
module tb_sensor_drain_dma;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_en = 1'b0;
    logic        irq_ack = 1'b0;
    logic [31:0] cfg_dst_base = '0;
    logic        busy, done_irq;
    logic [31:0] frame_sum;
    logic [15:0] frame_cnt;

    logic [31:0] mem [DEPTH];
    logic [31:0] wa_q[$], wd_q[$], sa_q[$], sd_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_clear = 0;

    sensor_drain_dma_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    sensor_drain_dma #(.DEPTH(64), .ADDR_W(6), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_en       (cfg_en),
        .cfg_dst_base (cfg_dst_base),
        .irq_ack      (irq_ack),
        .bus          (bus),
        .busy         (busy),
        .done_irq     (done_irq),
        .frame_sum    (frame_sum),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    assign bus.sctrl_out = mem[bus.sctrl_addr];

    // Inputs change at posedge+1, so the negedge sees what the next posedge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_valid && bus.wr_ready) begin
                wa_q.push_back(bus.wr_addr);
                wd_q.push_back(bus.wr_data);
            end
            if (bus.wr_valid && !bus.wr_ready) begin
                sa_q.push_back(bus.wr_addr);
                sd_q.push_back(bus.wr_data);
            end
            if (bus.sctrl_clear) n_clear++;
        end
    end

    task automatic clear_log;
        wa_q.delete(); wd_q.delete(); sa_q.delete(); sd_q.delete();
        n_clear = 0;
    endtask

    task automatic run_frame(input int stall_word, input int stall_len, input int drop_word,
                             input bit ack_in_write, output bit ok);
        int stalled = 0;
        bit acked = 0;
        ok = 0;
        bus.sctrl_interrupt = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (bus.sctrl_clear) bus.sctrl_interrupt = 1'b0;
            bus.wr_ready = 1'b1;
            if (bus.wr_valid && bus.sctrl_addr == stall_word && stalled < stall_len) begin
                bus.wr_ready = 1'b0;
                stalled++;
            end
            if (bus.wr_valid && bus.sctrl_addr == drop_word) cfg_en = 1'b0;
            if (ack_in_write && bus.wr_valid && !acked) begin
                irq_ack = 1'b1;
                acked = 1;
            end else begin
                irq_ack = 1'b0;
            end
            if (done_irq) begin
                ok = 1;
                break;
            end
        end
        irq_ack = 1'b0;
    endtask

    task automatic pulse_ack;
        irq_ack = 1'b1;
        @(posedge clk); #1;
        irq_ack = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1; cfg_en = 1'b0; irq_ack = 1'b0;
        bus.wr_ready = 1'b1; bus.sctrl_interrupt = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cfg_en = 1'b0; irq_ack = 1'b0;
        bus.wr_ready = 1'b1; bus.sctrl_interrupt = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({busy, done_irq} !== 2'b00) begin n_bad++;
            $display("FAIL reset_status busy/done got %b want 00", {busy, done_irq}); end
        n_cmp++; if ({bus.sctrl_en, bus.sctrl_clear, bus.wr_valid} !== 3'b000) begin n_bad++;
            $display("FAIL reset_strobes en/clear/valid got %b want 000",
                     {bus.sctrl_en, bus.sctrl_clear, bus.wr_valid}); end
        n_cmp++; if ({bus.sctrl_addr, bus.wr_addr, bus.wr_data} !== 70'h0) begin n_bad++;
            $display("FAIL reset_bus addr=%h wr_addr=%h wr_data=%h want 0",
                     bus.sctrl_addr, bus.wr_addr, bus.wr_data); end
        n_cmp++; if ({frame_sum, frame_cnt} !== 48'h0) begin n_bad++;
            $display("FAIL reset_counters sum=%h cnt=%h want 0", frame_sum, frame_cnt); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++;
            $display("FAIL idle_no_en busy got %b want 0", busy); end
    endtask

    task automatic test_single_frame;
        bit ok;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
        clear_log();
        cfg_dst_base = 32'h2000_0000;
        cfg_en = 1'b1;
        run_frame(-1, 0, -1, 0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL frame1_done timeout got 0 want done_irq"); end
        n_cmp++; if (wa_q.size() != DEPTH) begin n_bad++;
            $display("FAIL frame1_count got %0d want %0d", wa_q.size(), DEPTH); end
        for (int i = 0; i < wa_q.size() && i < DEPTH; i++) begin
            n_cmp++;
            if (wa_q[i] !== 32'h2000_0000 + 32'(i * 4) || wd_q[i] !== 32'(i)) begin n_bad++;
                $display("FAIL frame1_word%0d got %h/%h want %h/%h", i, wa_q[i], wd_q[i],
                         32'h2000_0000 + 32'(i * 4), 32'(i)); end
        end
        n_cmp++; if (n_clear != 1) begin n_bad++; $display("FAIL frame1_clear got %0d want 1", n_clear); end
        n_cmp++; if (frame_sum !== 32'd2016) begin n_bad++;
            $display("FAIL frame1_sum got %0d want 2016", frame_sum); end
        n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++;
            $display("FAIL frame1_cnt got %0d want 1", frame_cnt); end
        n_cmp++; if ({done_irq, busy, bus.sctrl_en} !== 3'b110) begin n_bad++;
            $display("FAIL frame1_done_state done/busy/en got %b want 110", {done_irq, busy, bus.sctrl_en}); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (done_irq !== 1'b1) begin n_bad++; $display("FAIL frame1_irq_level got 0 want 1"); end
        cfg_en = 1'b0;
        pulse_ack();
        n_cmp++; if ({busy, done_irq} !== 2'b00) begin n_bad++;
            $display("FAIL frame1_ack_idle busy/done got %b want 00", {busy, done_irq}); end
    endtask

    task automatic test_stall;
        bit ok;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA500_0000 + 32'(i);
        clear_log();
        cfg_dst_base = 32'h2000_0000;
        cfg_en = 1'b1;
        run_frame(5, 3, -1, 0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_done timeout got 0 want done_irq"); end
        n_cmp++; if (wa_q.size() != DEPTH) begin n_bad++;
            $display("FAIL stall_count got %0d want %0d", wa_q.size(), DEPTH); end
        for (int i = 0; i < wa_q.size() && i < DEPTH; i++) begin
            n_cmp++;
            if (wa_q[i] !== 32'h2000_0000 + 32'(i * 4) || wd_q[i] !== 32'hA500_0000 + 32'(i)) begin n_bad++;
                $display("FAIL stall_word%0d got %h/%h want %h/%h", i, wa_q[i], wd_q[i],
                         32'h2000_0000 + 32'(i * 4), 32'hA500_0000 + 32'(i)); end
        end
        n_cmp++; if (sa_q.size() != 3) begin n_bad++;
            $display("FAIL stall_cycles got %0d want 3", sa_q.size()); end
        for (int i = 0; i < sa_q.size(); i++) begin
            n_cmp++;
            if (sa_q[i] !== 32'h2000_0014 || sd_q[i] !== 32'hA500_0005) begin n_bad++;
                $display("FAIL stall_hold%0d got %h/%h want 20000014/a5000005", i, sa_q[i], sd_q[i]); end
        end
        n_cmp++; if (frame_sum !== 32'h4000_07E0) begin n_bad++;
            $display("FAIL stall_sum got %h want 400007e0", frame_sum); end
        n_cmp++; if (frame_cnt !== 16'd2) begin n_bad++;
            $display("FAIL stall_cnt got %0d want 2", frame_cnt); end
        cfg_en = 1'b0;
        pulse_ack();
    endtask

    task automatic test_addr_wrap;
        bit ok;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
        clear_log();
        cfg_dst_base = 32'hFFFF_FFF3;
        cfg_en = 1'b1;
        run_frame(-1, 0, -1, 0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_done timeout got 0 want done_irq"); end
        n_cmp++; if (wa_q.size() != DEPTH) begin n_bad++;
            $display("FAIL wrap_count got %0d want %0d", wa_q.size(), DEPTH); end
        if (wa_q.size() > 4) begin
            n_cmp++; if (wa_q[0] !== 32'hFFFF_FFF0) begin n_bad++;
                $display("FAIL wrap_first got %h want fffffff0", wa_q[0]); end
            n_cmp++; if (wa_q[4] !== 32'h0000_0000 || wd_q[4] !== 32'd4) begin n_bad++;
                $display("FAIL wrap_word4 got %h/%h want 00000000/00000004", wa_q[4], wd_q[4]); end
        end
        n_cmp++; if (frame_cnt !== 16'd3) begin n_bad++;
            $display("FAIL wrap_cnt got %0d want 3", frame_cnt); end
        cfg_en = 1'b0;
        pulse_ack();
    endtask

    task automatic test_disable_midframe;
        bit ok;
        clear_log();
        cfg_dst_base = 32'h2000_0000;
        cfg_en = 1'b1;
        run_frame(-1, 0, 10, 0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL drop_done timeout got 0 want done_irq"); end
        n_cmp++; if (cfg_en !== 1'b0) begin n_bad++; $display("FAIL drop_stimulus cfg_en never dropped"); end
        n_cmp++; if (wa_q.size() != DEPTH) begin n_bad++;
            $display("FAIL drop_count got %0d want %0d", wa_q.size(), DEPTH); end
        n_cmp++; if (n_clear != 1) begin n_bad++; $display("FAIL drop_clear got %0d want 1", n_clear); end
        n_cmp++; if (frame_cnt !== 16'd4) begin n_bad++;
            $display("FAIL drop_cnt got %0d want 4", frame_cnt); end
        pulse_ack();
        n_cmp++; if ({busy, bus.sctrl_en, done_irq} !== 3'b000) begin n_bad++;
            $display("FAIL drop_idle busy/en/done got %b want 000", {busy, bus.sctrl_en, done_irq}); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        do_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
        clear_log();
        cfg_dst_base = 32'h1000_0000;
        cfg_en = 1'b1;
        run_frame(-1, 0, -1, 1, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_first_done timeout got 0 want done_irq"); end
        n_cmp++; if (wa_q.size() != DEPTH || frame_cnt !== 16'd1) begin n_bad++;
            $display("FAIL b2b_first writes=%0d cnt=%0d want 64/1", wa_q.size(), frame_cnt); end
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i * 2);
        cfg_dst_base = 32'h3000_0000;
        pulse_ack();
        n_cmp++; if ({bus.sctrl_en, busy, done_irq} !== 3'b110) begin n_bad++;
            $display("FAIL b2b_rearm en/busy/done got %b want 110", {bus.sctrl_en, busy, done_irq}); end
        cfg_dst_base = 32'h4444_4444;
        clear_log();
        run_frame(-1, 0, -1, 0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_second_done timeout got 0 want done_irq"); end
        n_cmp++; if (wa_q.size() != DEPTH) begin n_bad++;
            $display("FAIL b2b_second_count got %0d want %0d", wa_q.size(), DEPTH); end
        for (int i = 0; i < wa_q.size() && i < DEPTH; i++) begin
            n_cmp++;
            if (wa_q[i] !== 32'h3000_0000 + 32'(i * 4) || wd_q[i] !== 32'(i * 2)) begin n_bad++;
                $display("FAIL b2b_word%0d got %h/%h want %h/%h", i, wa_q[i], wd_q[i],
                         32'h3000_0000 + 32'(i * 4), 32'(i * 2)); end
        end
        n_cmp++; if (frame_sum !== 32'd4032 || frame_cnt !== 16'd2) begin n_bad++;
            $display("FAIL b2b_totals sum=%0d cnt=%0d want 4032/2", frame_sum, frame_cnt); end
        cfg_en = 1'b0;
        pulse_ack();
    endtask

    task automatic test_reset_midframe;
        bit ok = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
        clear_log();
        cfg_dst_base = 32'h2000_0000;
        cfg_en = 1'b1;
        bus.wr_ready = 1'b1;
        bus.sctrl_interrupt = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (bus.wr_valid && bus.sctrl_addr == 6'd30) begin
                ok = 1;
                break;
            end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_reach timeout got 0 want word 30 write"); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({busy, bus.sctrl_en, bus.sctrl_clear, bus.wr_valid, done_irq} !== 5'b0) begin n_bad++;
            $display("FAIL rstmid_async strobes got %b want 00000",
                     {busy, bus.sctrl_en, bus.sctrl_clear, bus.wr_valid, done_irq}); end
        n_cmp++; if ({bus.sctrl_addr, bus.wr_addr, bus.wr_data} !== 70'h0) begin n_bad++;
            $display("FAIL rstmid_bus addr=%h wr_addr=%h wr_data=%h want 0",
                     bus.sctrl_addr, bus.wr_addr, bus.wr_data); end
        @(posedge clk); #1;
        n_cmp++; if ({frame_cnt, frame_sum} !== 48'h0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL rstmid_next cnt=%0d sum=%0d busy=%b want 0/0/0", frame_cnt, frame_sum, busy); end
        n_cmp++; if (n_clear != 0) begin n_bad++; $display("FAIL rstmid_clear got %0d want 0", n_clear); end
        cfg_en = 1'b0;
        bus.sctrl_interrupt = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({busy, bus.sctrl_en} !== 2'b00) begin n_bad++;
            $display("FAIL rstmid_stay_idle busy/en got %b want 00", {busy, bus.sctrl_en}); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.wr_ready = 1'b1;
        bus.sctrl_interrupt = 1'b0;
        test_reset();
        test_single_frame();
        test_stall();
        test_addr_wrap();
        test_disable_midframe();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
